// File: rtl/instr_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: mode encodings and a width helper.
package instr_dispatcher_pkg;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_SKIP   = 1'b1;

  // Ceiling log2, floored at 1 so index fields never collapse to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Per-lane sync FIFO: push visible at dout the next cycle; push ignored when full, pop ignored when empty.
// An empty FIFO keeps presenting the last word that sat at its head.
module dispatch_fifo
  import instr_dispatcher_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] last_head;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (!empty) last_head <= mem[rd_ptr];
    end
  end

  // Storage is datapath only; validity is tracked by count, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? last_head : mem[rd_ptr];

endmodule

// File: rtl/instr_dispatcher.sv
// Spreads an instruction stream over NUM_CH lane FIFOs (strict round-robin or skip-full); 1-cycle latency.
// in_ready is decoded from registered lane counts only; a full target (strict) or all-full (skip) stalls input.
module instr_dispatcher
  import instr_dispatcher_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 4,
  localparam int CH_W   = clog2(NUM_CH),
  localparam int CNT_W  = clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*CNT_W-1:0]  lane_cnt,
  output logic [CH_W-1:0]          next_lane
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [CH_W-1:0]   skip_target;
  logic [CH_W-1:0]   target;
  logic              found;
  logic              lane_ok;
  logic              accept;
  int                idx;

  // Priority search over lanes, rotated so the scan starts at next_lane.
  always_comb begin
    found       = 1'b0;
    skip_target = next_lane;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(next_lane) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && !full[idx[CH_W-1:0]]) begin
        found       = 1'b1;
        skip_target = idx[CH_W-1:0];
      end
    end
  end

  assign target   = (mode == MODE_SKIP) ? skip_target : next_lane;
  assign lane_ok  = (mode == MODE_SKIP) ? found : !full[next_lane];
  assign in_ready = resetn && lane_ok;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_lane <= '0;
    end else if (accept) begin
      next_lane <= (target == CH_W'(NUM_CH - 1)) ? '0 : target + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic [CNT_W-1:0]  count;

    assign push[i] = accept && (target == CH_W'(i));

    dispatch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[i]),
      .din    (in_data),
      .pop    (out_ready[i]),
      .dout   (dout),
      .empty  (empty),
      .full   (full[i]),
      .count  (count)
    );

    assign out_valid[i]                 = !empty;
    assign out_data[i*DATA_W +: DATA_W] = dout;
    assign lane_cnt[i*CNT_W +: CNT_W]   = count;
  end

endmodule
